// File: rtl/prog_imem_pkg.sv
// Shared types and constants for the program instruction memory.
package prog_imem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;
  localparam int unsigned LD_WORDS_W       = 16;

  typedef logic [LD_WORDS_W-1:0] ld_words_t;

endpackage

// File: rtl/prog_imem_if.sv
// Fetch port and byte-stream load port of the program instruction memory.
interface prog_imem_if;
  import prog_imem_pkg::*;

  logic        FETCH_REQ;
  logic [31:0] A;
  logic [31:0] RD;
  logic        RD_VALID;
  logic        LD_START;
  logic [31:0] LD_BASE;
  logic        LD_BYTE_VALID;
  logic [7:0]  LD_BYTE;
  logic        LD_END;
  logic        BUSY;
  logic        LD_ERR;
  ld_words_t   LD_WORDS;

  modport master (
    output FETCH_REQ, A, LD_START, LD_BASE, LD_BYTE_VALID, LD_BYTE, LD_END,
    input  RD, RD_VALID, BUSY, LD_ERR, LD_WORDS
  );

  modport slave (
    input  FETCH_REQ, A, LD_START, LD_BASE, LD_BYTE_VALID, LD_BYTE, LD_END,
    output RD, RD_VALID, BUSY, LD_ERR, LD_WORDS
  );

endinterface

// File: rtl/imem_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; pulses word_we on a
// full word or on a flush with pending bytes (unfilled lanes read as zero).
module imem_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic        word_we,
  output logic [31:0] word_out
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] lanes_q, lanes_d;

  always_comb begin
    word_out = lanes_q;
    if (byte_valid) begin
      unique case (cnt_q)
        2'd0: word_out[7:0]   = byte_in;
        2'd1: word_out[15:8]  = byte_in;
        2'd2: word_out[23:16] = byte_in;
        2'd3: word_out[31:24] = byte_in;
      endcase
    end
  end

  // A byte arriving with the flush is merged before the partial word goes out.
  assign word_we = (byte_valid && (cnt_q == 2'd3))
                || (flush && (byte_valid || (cnt_q != 2'd0)));

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (clear || word_we) begin
      cnt_d   = '0;
      lanes_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      lanes_d = word_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/prog_imem.sv
// Program instruction memory: registered single-cycle fetch port plus a
// byte-stream loader that writes words starting at a programmable base.
module prog_imem
  import prog_imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  prog_imem_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem_q [0:DEPTH-1] = '{default: NOP_WORD};

  state_e      state_q, state_d;
  logic [29:0] ptr_q, ptr_d;
  ld_words_t   ld_words_q, ld_words_d;
  logic        ld_err_q, ld_err_d;
  logic [31:0] rd_q, rd_d;
  logic        rd_valid_q, rd_valid_d;

  logic        in_load;
  logic        asm_valid, asm_flush, asm_we;
  logic [31:0] asm_word;
  logic        ptr_in_range, mem_we;
  logic [29:0] fetch_word;
  logic        fetch_oob;

  assign in_load   = (state_q == ST_LOAD);
  // A restart takes priority over any byte or end pulse in the same cycle.
  assign asm_valid = in_load && bus.LD_BYTE_VALID && !bus.LD_START;
  assign asm_flush = in_load && bus.LD_END && !bus.LD_START;

  imem_byte_assembler u_asm (
    .clk        (CLK),
    .rst        (RST),
    .clear      (bus.LD_START),
    .byte_valid (asm_valid),
    .byte_in    (bus.LD_BYTE),
    .flush      (asm_flush),
    .word_we    (asm_we),
    .word_out   (asm_word)
  );

  assign ptr_in_range = (ptr_q < 30'(DEPTH));
  assign mem_we       = asm_we && ptr_in_range;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ld_words_d = ld_words_q;
    ld_err_d   = ld_err_q;
    if (bus.LD_START) begin
      state_d    = ST_LOAD;
      ptr_d      = bus.LD_BASE[31:2];
      ld_words_d = '0;
      ld_err_d   = 1'b0;
    end else if (in_load) begin
      if (asm_we) begin
        ptr_d = ptr_q + 30'd1;
        if (ld_words_q != '1) ld_words_d = ld_words_q + ld_words_t'(1);
        if (!ptr_in_range) ld_err_d = 1'b1;
      end
      if (asm_flush) state_d = ST_IDLE;
    end
  end

  assign fetch_word = bus.A[31:2];
  assign fetch_oob  = (fetch_word >= 30'(DEPTH));

  always_comb begin
    rd_valid_d = bus.FETCH_REQ;
    rd_d       = rd_q;
    if (bus.FETCH_REQ) begin
      if (in_load || fetch_oob) rd_d = NOP_WORD;
      else                      rd_d = mem_q[fetch_word[AW-1:0]];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ld_words_q <= '0;
      ld_err_q   <= 1'b0;
      rd_q       <= NOP_WORD;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_words_q <= ld_words_d;
      ld_err_q   <= ld_err_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Contents survive reset; a same-cycle fetch sees the pre-write word.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[ptr_q[AW-1:0]] <= asm_word;
  end

  assign bus.RD       = rd_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.BUSY     = in_load;
  assign bus.LD_ERR   = ld_err_q;
  assign bus.LD_WORDS = ld_words_q;

endmodule

// File: tb/tb_prog_imem.sv
// Scoreboard-driven bench for prog_imem: fetch expectations are queued when
// requests are driven and compared when RD_VALID answers.
module tb_prog_imem;
  import prog_imem_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q [$];
  logic        req_at_edge = 1'b0;

  prog_imem_if bus ();

  prog_imem #(.DEPTH(64), .NOP_WORD(NOP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) req_at_edge <= bus.FETCH_REQ && !RST;

  always @(negedge CLK) begin
    checks++;
    if (req_at_edge) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_scoreboard: response with empty queue, RD=%h", bus.RD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.RD_VALID !== 1'b1 || bus.RD !== e) begin
          errors++;
          $display("FAIL rd_fetch: RD_VALID=%b RD=%h expected RD_VALID=1 RD=%h",
                   bus.RD_VALID, bus.RD, e);
        end
      end
    end else if (bus.RD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_idle: RD_VALID=%b expected 0", bus.RD_VALID);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic ld_start(input logic [31:0] base);
    bus.LD_START = 1'b1;
    bus.LD_BASE  = base;
    @(posedge CLK); #1;
    bus.LD_START = 1'b0;
  endtask

  task automatic ld_byte(input logic [7:0] b, input logic with_end);
    bus.LD_BYTE_VALID = 1'b1;
    bus.LD_BYTE       = b;
    bus.LD_END        = with_end;
    @(posedge CLK); #1;
    bus.LD_BYTE_VALID = 1'b0;
    bus.LD_END        = 1'b0;
  endtask

  task automatic ld_end();
    bus.LD_END = 1'b1;
    @(posedge CLK); #1;
    bus.LD_END = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] expect_rd);
    bus.FETCH_REQ = 1'b1;
    bus.A         = addr;
    exp_q.push_back(expect_rd);
    @(posedge CLK); #1;
    bus.FETCH_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if (bus.RD !== NOP || bus.BUSY !== 1'b0 || bus.LD_ERR !== 1'b0 || bus.LD_WORDS !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: RD=%h BUSY=%b LD_ERR=%b LD_WORDS=%0d expected %h 0 0 0",
               bus.RD, bus.BUSY, bus.LD_ERR, bus.LD_WORDS, NOP);
    end
    fetch(32'h0, NOP);
  endtask

  task automatic test_load();
    ld_start(32'h10);
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL load_busy: BUSY=%b expected 1", bus.BUSY);
    end
    ld_byte(8'h93, 1'b0);
    ld_byte(8'h00, 1'b0);
    ld_byte(8'h10, 1'b0);
    ld_byte(8'h00, 1'b0);
    ld_end();
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.LD_WORDS !== 16'd1 || bus.LD_ERR !== 1'b0) begin
      errors++;
      $display("FAIL load_status: BUSY=%b LD_WORDS=%0d LD_ERR=%b expected 0 1 0",
               bus.BUSY, bus.LD_WORDS, bus.LD_ERR);
    end
    fetch(32'h10, 32'h0010_0093);
  endtask

  task automatic test_idle_ignore();
    bus.LD_BYTE_VALID = 1'b1;
    bus.LD_BYTE       = 8'hFF;
    bus.LD_END        = 1'b1;
    @(posedge CLK); #1;
    bus.LD_BYTE_VALID = 1'b0;
    bus.LD_END        = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.LD_WORDS !== 16'd1) begin
      errors++;
      $display("FAIL idle_ignore: BUSY=%b LD_WORDS=%0d expected 0 1", bus.BUSY, bus.LD_WORDS);
    end
    fetch(32'h10, 32'h0010_0093);
  endtask

  task automatic test_partial();
    ld_start(32'h20);
    ld_byte(8'hAA, 1'b0);
    ld_byte(8'hBB, 1'b0);
    ld_end();
    @(negedge CLK);
    checks++;
    if (bus.LD_WORDS !== 16'd1) begin
      errors++;
      $display("FAIL partial_words: LD_WORDS=%0d expected 1", bus.LD_WORDS);
    end
    fetch(32'h20, 32'h0000_BBAA);
  endtask

  task automatic test_bounds();
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ld_start(32'hFC);
    for (int i = 0; i < 8; i++) ld_byte(bytes[i], 1'b0);
    ld_end();
    @(negedge CLK);
    checks++;
    if (bus.LD_ERR !== 1'b1 || bus.LD_WORDS !== 16'd2) begin
      errors++;
      $display("FAIL bounds_status: LD_ERR=%b LD_WORDS=%0d expected 1 2", bus.LD_ERR, bus.LD_WORDS);
    end
    fetch(32'hFC, 32'h4433_2211);
    fetch(32'h100, NOP);
    fetch(32'h0, NOP);
  endtask

  task automatic test_busy();
    ld_start(32'h10);
    @(negedge CLK);
    checks++;
    if (bus.LD_ERR !== 1'b0 || bus.LD_WORDS !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear: LD_ERR=%b LD_WORDS=%0d expected 0 0", bus.LD_ERR, bus.LD_WORDS);
    end
    ld_byte(8'h01, 1'b0);
    ld_byte(8'h02, 1'b0);
    ld_byte(8'h03, 1'b0);
    // Final byte writes word 4 while a fetch of word 4 is in flight.
    bus.FETCH_REQ = 1'b1;
    bus.A         = 32'h10;
    exp_q.push_back(NOP);
    ld_byte(8'h04, 1'b0);
    bus.FETCH_REQ = 1'b0;
    ld_end();
    @(negedge CLK);
    fetch(32'h10, 32'h0403_0201);
  endtask

  task automatic test_rst_mid_load();
    ld_start(32'h30);
    ld_byte(8'h55, 1'b0);
    ld_byte(8'h66, 1'b0);
    RST = 1'b1;
    #1;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.LD_WORDS !== 16'd0 || bus.RD !== NOP) begin
      errors++;
      $display("FAIL rst_mid_load: BUSY=%b LD_WORDS=%0d RD=%h expected 0 0 %h",
               bus.BUSY, bus.LD_WORDS, bus.RD, NOP);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    fetch(32'h30, NOP);
    fetch(32'h10, 32'h0403_0201);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h40, 32'h44, 32'h48};
    logic [31:0] words [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_00EF};
    ld_start(32'h40);
    ld_byte(8'hEF, 1'b0); ld_byte(8'hBE, 1'b0); ld_byte(8'hAD, 1'b0); ld_byte(8'hDE, 1'b0);
    ld_byte(8'h78, 1'b0); ld_byte(8'h56, 1'b0); ld_byte(8'h34, 1'b0); ld_byte(8'h12, 1'b0);
    ld_byte(8'hEF, 1'b1);
    @(negedge CLK);
    checks++;
    if (bus.LD_WORDS !== 16'd3 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL end_with_byte: LD_WORDS=%0d BUSY=%b expected 3 0", bus.LD_WORDS, bus.BUSY);
    end
    for (int i = 0; i < 3; i++) begin
      bus.FETCH_REQ = 1'b1;
      bus.A         = addrs[i];
      exp_q.push_back(words[i]);
      @(posedge CLK); #1;
    end
    bus.FETCH_REQ = 1'b0;
    bus.A         = 32'h40;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.RD !== 32'h0000_00EF) begin
      errors++;
      $display("FAIL rd_hold: RD=%h expected %h", bus.RD, 32'h0000_00EF);
    end
    // Restart mid-word: the two pending bytes must never reach memory.
    ld_start(32'h80);
    ld_byte(8'h01, 1'b0);
    ld_byte(8'h02, 1'b0);
    ld_start(32'h84);
    ld_byte(8'hA1, 1'b0); ld_byte(8'hB2, 1'b0); ld_byte(8'hC3, 1'b0); ld_byte(8'hD4, 1'b0);
    ld_end();
    @(negedge CLK);
    checks++;
    if (bus.LD_WORDS !== 16'd1) begin
      errors++;
      $display("FAIL restart_words: LD_WORDS=%0d expected 1", bus.LD_WORDS);
    end
    fetch(32'h80, NOP);
    fetch(32'h84, 32'hD4C3_B2A1);
  endtask

  initial begin
    bus.FETCH_REQ     = 1'b0;
    bus.A             = '0;
    bus.LD_START      = 1'b0;
    bus.LD_BASE       = '0;
    bus.LD_BYTE_VALID = 1'b0;
    bus.LD_BYTE       = '0;
    bus.LD_END        = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    test_reset();
    test_load();
    test_idle_ignore();
    test_partial();
    test_bounds();
    test_busy();
    test_rst_mid_load();
    test_back_to_back();

    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
